multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 26 ++
 rtl/wait_timer.sv | 33 +++
 rtl/multicycle_ctrl.sv | 160 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle controller
// Purpose: state codes, opcode constants and pc_src selects used by
//          multicycle_ctrl and its bench.
// Ports:   none (package)
package ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - memory wait counter with timeout flag
// Purpose: counts wait cycles while a memory request is outstanding.
// Ports:   clk, rst_n  - clock, asynchronous active-low reset
//          clear       - return the count to 0 (has priority over count)
//          count       - advance the count by one
//          expired     - count has reached TIMEOUT-1
module wait_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (count) begin
         cnt <= cnt + W'(1);
      end
   end

   assign expired = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM with memory timeout
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath enables.
// Ports:   clk, rst_n                 - clock, asynchronous active-low reset
//          run                        - permits a new instruction fetch
//          opcode, zero, mem_ready    - IR[31:26], ALU zero, memory done
//          mem_req, mem_we, iord      - memory request / write / address select
//          pc_en .. alu_out_en        - datapath register enables
//          pc_src, rf_we              - next-PC select, register-file write
//          state, illegal, err        - current state, bad opcode, timeout
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       pc_en,
   output logic       ir_en,
   output logic       mdr_en,
   output logic       a_en,
   output logic       b_en,
   output logic       alu_out_en,
   output logic [1:0] pc_src,
   output logic       rf_we,
   output logic [2:0] state,
   output logic       illegal,
   output logic       err
);

   state_t state_q, state_d;
   logic   waiting;
   logic   expired;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      waiting    = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      pc_en      = 1'b0;
      ir_en      = 1'b0;
      mdr_en     = 1'b0;
      a_en       = 1'b0;
      b_en       = 1'b0;
      alu_out_en = 1'b0;
      pc_src     = PC_SRC_SEQ;
      rf_we      = 1'b0;
      illegal    = 1'b0;
      err        = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (run) begin
               mem_req = 1'b1;
               waiting = 1'b1;
               if (mem_ready) begin
                  ir_en   = 1'b1;
                  pc_en   = 1'b1;
                  state_d = ST_DECODE;
               end else if (expired) begin
                  // Abort with no enables: PC is untouched so the fetch retries.
                  err = 1'b1;
               end
            end
         end
         ST_DECODE: begin
            a_en       = 1'b1;
            b_en       = 1'b1;
            alu_out_en = 1'b1;
            case (opcode)
               OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = ST_EXEC;
               OP_J: begin
                  pc_en   = 1'b1;
                  pc_src  = PC_SRC_JUMP;
                  state_d = ST_FETCH;
               end
               default: begin
                  illegal = 1'b1;
                  state_d = ST_FETCH;
               end
            endcase
         end
         ST_EXEC: begin
            if (opcode == OP_BEQ) begin
               pc_en   = zero;
               pc_src  = PC_SRC_BRANCH;
               state_d = ST_FETCH;
            end else begin
               alu_out_en = 1'b1;
               if (opcode == OP_LW || opcode == OP_SW)       state_d = ST_MEM;
               else if (opcode == OP_R || opcode == OP_ADDI) state_d = ST_WB;
               else                                          state_d = ST_FETCH;
            end
         end
         ST_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            mem_we  = (opcode == OP_SW);
            waiting = 1'b1;
            if (mem_ready) begin
               if (opcode == OP_LW) begin
                  mdr_en  = 1'b1;
                  state_d = ST_WB;
               end else begin
                  state_d = ST_FETCH;
               end
            end else if (expired) begin
               err     = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_WB: begin
            rf_we   = 1'b1;
            state_d = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase

      // Outputs must be quiet for the whole reset assertion, not just from the
      // next edge, so gate them directly with rst_n.
      if (!rst_n) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         iord       = 1'b0;
         pc_en      = 1'b0;
         ir_en      = 1'b0;
         mdr_en     = 1'b0;
         a_en       = 1'b0;
         b_en       = 1'b0;
         alu_out_en = 1'b0;
         pc_src     = PC_SRC_SEQ;
         rf_we      = 1'b0;
         illegal    = 1'b0;
         err        = 1'b0;
      end
   end

   assign state = state_q;

   // err is included in clear because a FETCH timeout stays in FETCH.
   wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!waiting || mem_ready || err || (state_d != state_q)),
      .count   (waiting && !mem_ready),
      .expired (expired)
   );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
// Purpose: drives per-cycle stimulus tables and compares every output.
// Ports:   none (top-level bench)
module tb_multicycle_ctrl;
   import ctrl_pkg::*;

   localparam int REQ = 1, WE = 2, IORD = 4, PCE = 8, IRE = 16, MDR = 32;
   localparam int AE = 64, BE = 128, ALU = 256, RFW = 512, ILL = 1024, ERR = 2048;
   localparam int DEC = AE | BE | ALU;

   typedef struct packed {
      logic [2:0] state;
      logic       mem_req, mem_we, iord, pc_en, ir_en, mdr_en, a_en, b_en, alu_out_en;
      logic [1:0] pc_src;
      logic       rf_we, illegal, err;
   } outs_t;

   typedef struct {
      logic       rst;
      logic       run;
      logic       rdy;
      logic       z;
      logic [5:0] op;
      outs_t      e;
   } stim_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, iord, pc_en, ir_en, mdr_en, a_en, b_en, alu_out_en;
   logic [1:0] pc_src;
   logic       rf_we, illegal, err;
   logic [2:0] state;

   int    errors = 0;
   int    checks = 0;
   outs_t exp_q[$];

   always #5 clk = ~clk;

   multicycle_ctrl #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .pc_en(pc_en), .ir_en(ir_en), .mdr_en(mdr_en), .a_en(a_en), .b_en(b_en),
      .alu_out_en(alu_out_en), .pc_src(pc_src), .rf_we(rf_we), .state(state),
      .illegal(illegal), .err(err)
   );

   function automatic outs_t mk(input logic [2:0] st, input int f, input logic [1:0] ps);
      outs_t o;
      o.state      = st;
      o.mem_req    = (f & REQ)  != 0;
      o.mem_we     = (f & WE)   != 0;
      o.iord       = (f & IORD) != 0;
      o.pc_en      = (f & PCE)  != 0;
      o.ir_en      = (f & IRE)  != 0;
      o.mdr_en     = (f & MDR)  != 0;
      o.a_en       = (f & AE)   != 0;
      o.b_en       = (f & BE)   != 0;
      o.alu_out_en = (f & ALU)  != 0;
      o.pc_src     = ps;
      o.rf_we      = (f & RFW)  != 0;
      o.illegal    = (f & ILL)  != 0;
      o.err        = (f & ERR)  != 0;
      return o;
   endfunction

   function automatic stim_t cyc(input logic r, input logic rn, input logic rdy, input logic z,
                                 input logic [5:0] op, input logic [2:0] st, input int f,
                                 input logic [1:0] ps);
      stim_t s;
      s.rst = r; s.run = rn; s.rdy = rdy; s.z = z; s.op = op;
      s.e = mk(st, f, ps);
      return s;
   endfunction

   function automatic outs_t sample();
      outs_t o;
      o = {state, mem_req, mem_we, iord, pc_en, ir_en, mdr_en, a_en, b_en, alu_out_en,
           pc_src, rf_we, illegal, err};
      return o;
   endfunction

   // Applies one cycle of inputs just after the rising edge and queues its
   // expectation; returns at the falling edge, ready for the caller to compare.
   task automatic drive_cycle(input stim_t s);
      @(posedge clk);
      #1;
      rst_n     = s.rst;
      run       = s.run;
      mem_ready = s.rdy;
      zero      = s.z;
      opcode    = s.op;
      exp_q.push_back(s.e);
      @(negedge clk);
   endtask

   task automatic test_reset();
      stim_t t[$];
      outs_t e, got;
      t.push_back(cyc(0, 1, 1, 0, OP_R, 0, 0, 2'b00));
      t.push_back(cyc(0, 1, 1, 0, OP_R, 0, 0, 2'b00));
      t.push_back(cyc(1, 0, 1, 0, OP_R, 0, 0, 2'b00));
      t.push_back(cyc(1, 0, 1, 0, OP_R, 0, 0, 2'b00));
      foreach (t[i]) begin
         drive_cycle(t[i]);
         e = exp_q.pop_front(); got = sample(); checks++;
         if (got !== e) begin
            errors++; $display("FAIL reset[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_r_type();
      stim_t t[$];
      outs_t e, got;
      t.push_back(cyc(1, 1, 1, 0, OP_R, 0, REQ | IRE | PCE, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_R, 1, DEC, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_R, 2, ALU, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_R, 4, RFW, 2'b00));
      t.push_back(cyc(1, 0, 1, 0, OP_R, 0, 0, 2'b00));
      foreach (t[i]) begin
         drive_cycle(t[i]);
         e = exp_q.pop_front(); got = sample(); checks++;
         if (got !== e) begin
            errors++; $display("FAIL r_type[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_lw_wait();
      stim_t t[$];
      outs_t e, got;
      t.push_back(cyc(1, 1, 1, 0, OP_LW, 0, REQ | IRE | PCE, 2'b00));
      t.push_back(cyc(1, 0, 0, 0, OP_LW, 1, DEC, 2'b00));
      t.push_back(cyc(1, 0, 0, 0, OP_LW, 2, ALU, 2'b00));
      for (int k = 0; k < 3; k++) t.push_back(cyc(1, 0, 0, 0, OP_LW, 3, REQ | IORD, 2'b00));
      t.push_back(cyc(1, 0, 1, 0, OP_LW, 3, REQ | IORD | MDR, 2'b00));
      t.push_back(cyc(1, 0, 0, 0, OP_LW, 4, RFW, 2'b00));
      t.push_back(cyc(1, 0, 0, 0, OP_LW, 0, 0, 2'b00));
      foreach (t[i]) begin
         drive_cycle(t[i]);
         e = exp_q.pop_front(); got = sample(); checks++;
         if (got !== e) begin
            errors++; $display("FAIL lw_wait[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_beq();
      stim_t t[$];
      outs_t e, got;
      t.push_back(cyc(1, 1, 1, 1, OP_BEQ, 0, REQ | IRE | PCE, 2'b00));
      t.push_back(cyc(1, 1, 1, 1, OP_BEQ, 1, DEC, 2'b00));
      t.push_back(cyc(1, 1, 1, 1, OP_BEQ, 2, PCE, 2'b01));
      t.push_back(cyc(1, 1, 1, 0, OP_BEQ, 0, REQ | IRE | PCE, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_BEQ, 1, DEC, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_BEQ, 2, 0, 2'b01));
      t.push_back(cyc(1, 0, 1, 0, OP_BEQ, 0, 0, 2'b00));
      foreach (t[i]) begin
         drive_cycle(t[i]);
         e = exp_q.pop_front(); got = sample(); checks++;
         if (got !== e) begin
            errors++; $display("FAIL beq[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_illegal();
      stim_t t[$];
      outs_t e, got;
      t.push_back(cyc(1, 1, 1, 0, 6'b111111, 0, REQ | IRE | PCE, 2'b00));
      t.push_back(cyc(1, 0, 1, 0, 6'b111111, 1, DEC | ILL, 2'b00));
      t.push_back(cyc(1, 0, 1, 0, 6'b111111, 0, 0, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_J, 0, REQ | IRE | PCE, 2'b00));
      t.push_back(cyc(1, 0, 1, 0, OP_J, 1, DEC | PCE, 2'b10));
      t.push_back(cyc(1, 0, 1, 0, OP_J, 0, 0, 2'b00));
      foreach (t[i]) begin
         drive_cycle(t[i]);
         e = exp_q.pop_front(); got = sample(); checks++;
         if (got !== e) begin
            errors++; $display("FAIL illegal_jump[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_timeout_fetch();
      stim_t t[$];
      outs_t e, got;
      for (int k = 0; k < 15; k++) t.push_back(cyc(1, 1, 0, 0, OP_J, 0, REQ, 2'b00));
      t.push_back(cyc(1, 1, 0, 0, OP_J, 0, REQ | ERR, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_J, 0, REQ | IRE | PCE, 2'b00));
      t.push_back(cyc(1, 0, 0, 0, OP_J, 1, DEC | PCE, 2'b10));
      for (int k = 0; k < 15; k++) t.push_back(cyc(1, 1, 0, 0, OP_J, 0, REQ, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_J, 0, REQ | IRE | PCE, 2'b00));
      t.push_back(cyc(1, 0, 0, 0, OP_J, 1, DEC | PCE, 2'b10));
      t.push_back(cyc(1, 0, 0, 0, OP_J, 0, 0, 2'b00));
      foreach (t[i]) begin
         drive_cycle(t[i]);
         e = exp_q.pop_front(); got = sample(); checks++;
         if (got !== e) begin
            errors++; $display("FAIL timeout_fetch[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_timeout_mem();
      stim_t t[$];
      outs_t e, got;
      t.push_back(cyc(1, 1, 1, 0, OP_LW, 0, REQ | IRE | PCE, 2'b00));
      t.push_back(cyc(1, 0, 0, 0, OP_LW, 1, DEC, 2'b00));
      t.push_back(cyc(1, 0, 0, 0, OP_LW, 2, ALU, 2'b00));
      for (int k = 0; k < 15; k++) t.push_back(cyc(1, 0, 0, 0, OP_LW, 3, REQ | IORD, 2'b00));
      t.push_back(cyc(1, 0, 0, 0, OP_LW, 3, REQ | IORD | ERR, 2'b00));
      t.push_back(cyc(1, 0, 0, 0, OP_LW, 0, 0, 2'b00));
      foreach (t[i]) begin
         drive_cycle(t[i]);
         e = exp_q.pop_front(); got = sample(); checks++;
         if (got !== e) begin
            errors++; $display("FAIL timeout_mem[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_reset_mid_mem();
      stim_t t[$];
      outs_t e, got;
      t.push_back(cyc(1, 1, 1, 0, OP_SW, 0, REQ | IRE | PCE, 2'b00));
      t.push_back(cyc(1, 0, 0, 0, OP_SW, 1, DEC, 2'b00));
      t.push_back(cyc(1, 0, 0, 0, OP_SW, 2, ALU, 2'b00));
      t.push_back(cyc(1, 0, 0, 0, OP_SW, 3, REQ | IORD | WE, 2'b00));
      foreach (t[i]) begin
         drive_cycle(t[i]);
         e = exp_q.pop_front(); got = sample(); checks++;
         if (got !== e) begin
            errors++; $display("FAIL sw_pre_reset[%0d]: got %h expected %h", i, got, e);
         end
      end
      @(posedge clk);
      #2;
      exp_q.push_back(mk(3, REQ | IORD | WE, 2'b00));
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
         errors++; $display("FAIL sw_mem_hold: got %h expected %h", got, e);
      end
      rst_n = 1'b0;
      mem_ready = 1'b1;
      #1;
      exp_q.push_back(mk(0, 0, 2'b00));
      e = exp_q.pop_front(); got = sample(); checks++;
      if (got !== e) begin
         errors++; $display("FAIL reset_mid_mem: got %h expected %h", got, e);
      end
      t.delete();
      t.push_back(cyc(0, 1, 1, 0, OP_SW, 0, 0, 2'b00));
      t.push_back(cyc(1, 0, 1, 0, OP_SW, 0, 0, 2'b00));
      foreach (t[i]) begin
         drive_cycle(t[i]);
         e = exp_q.pop_front(); got = sample(); checks++;
         if (got !== e) begin
            errors++; $display("FAIL post_reset[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t t[$];
      outs_t e, got;
      t.push_back(cyc(1, 1, 1, 0, OP_ADDI, 0, REQ | IRE | PCE, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_ADDI, 1, DEC, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_ADDI, 2, ALU, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_ADDI, 4, RFW, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_SW, 0, REQ | IRE | PCE, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_SW, 1, DEC, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_SW, 2, ALU, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_SW, 3, REQ | IORD | WE, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_J, 0, REQ | IRE | PCE, 2'b00));
      t.push_back(cyc(1, 1, 1, 0, OP_J, 1, DEC | PCE, 2'b10));
      t.push_back(cyc(1, 0, 1, 0, OP_J, 0, 0, 2'b00));
      foreach (t[i]) begin
         drive_cycle(t[i]);
         e = exp_q.pop_front(); got = sample(); checks++;
         if (got !== e) begin
            errors++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, e);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_r_type();
      test_lw_wait();
      test_beq();
      test_illegal();
      test_timeout_fetch();
      test_timeout_mem();
      test_reset_mid_mem();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
